// File: rtl/div_arbiter.sv
// div_arbiter: round-robin front end that shares a single start/busy/done
// divider among N_REQ requesters, one operation at a time.
//
// Handshake: requester i holds req[i] high with a_in/d_in stable until it
// sees the one-cycle gnt[i] pulse, which marks the edge its operands were
// captured. After gnt[i], a req[i] that stays high is a new request. The
// result comes back as a one-cycle resp_valid[i] pulse. resp_q/resp_r hold
// until the next response, and resp_dz/resp_to clear at the next grant.
module div_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] d_in,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   resp_valid,
  output logic [W-1:0]       resp_q,
  output logic [W-1:0]       resp_r,
  output logic               resp_dz,
  output logic               resp_to,
  output logic               arb_busy,
  output logic               div_start,
  output logic [W-1:0]       div_A,
  output logic [W-1:0]       div_D,
  input  logic [2*W-1:0]     div_R,
  input  logic               div_busy,
  input  logic               div_done,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_issue = 2'd1,
    st_wait  = 2'd2,
    st_resp  = 2'd3
  } state_t;

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] ptr;
  logic [IW-1:0] id;
  logic [IW-1:0] pick;
  logic [IW-1:0] scan_idx;
  logic          pick_vld;
  logic [W-1:0]  pick_a;
  logic [W-1:0]  pick_d;
  logic [CW-1:0] cnt;
  logic          wd_fire;
  logic [W-1:0]  res_q;
  logic [W-1:0]  res_r;
  logic          res_dz;
  logic          res_to;

  assign state_dbg = state;
  assign wd_fire   = (TIMEOUT != 0) && (cnt == TO_LAST);

  // Round-robin pick: scan from ptr upward; walking the offsets from high to
  // low lets the set bit nearest to ptr overwrite the others.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    scan_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = IW'((int'(ptr) + k) % N_REQ);
      if (req[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Operands of the requester that would be granted this cycle.
  always_comb begin
    pick_a = a_in[pick*W +: W];
    pick_d = d_in[pick*W +: W];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= st_idle;
    else        state <= state_nx;
  end

  // Next-state logic; a zero divisor skips the divider entirely.
  always_comb begin
    state_nx = state;
    case (state)
      st_idle:  if (pick_vld) state_nx = (pick_d == '0) ? st_resp : st_issue;
      st_issue: if (!div_busy) state_nx = st_wait;
      st_wait:  if (div_done || wd_fire) state_nx = st_resp;
      st_resp:  state_nx = st_idle;
      default:  state_nx = st_idle;
    endcase
  end

  // Registered outputs and datapath, all keyed on the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      resp_valid <= '0;
      div_start  <= 1'b0;
      arb_busy   <= 1'b0;
      resp_q     <= '0;
      resp_r     <= '0;
      resp_dz    <= 1'b0;
      resp_to    <= 1'b0;
      div_A      <= '0;
      div_D      <= '0;
      ptr        <= '0;
      id         <= '0;
      cnt        <= '0;
      res_q      <= '0;
      res_r      <= '0;
      res_dz     <= 1'b0;
      res_to     <= 1'b0;
    end else begin
      gnt        <= '0;
      resp_valid <= '0;
      div_start  <= 1'b0;
      arb_busy   <= (state_nx != st_idle);
      case (state)
        st_idle: begin
          if (pick_vld) begin
            gnt     <= ONE << pick;
            id      <= pick;
            div_A   <= pick_a;
            div_D   <= pick_d;
            resp_dz <= 1'b0;
            resp_to <= 1'b0;
            // Preload the divide-by-zero answer; a real division overwrites it.
            res_q   <= '1;
            res_r   <= pick_a;
            res_dz  <= (pick_d == '0);
            res_to  <= 1'b0;
          end
        end
        st_issue: begin
          if (!div_busy) begin
            div_start <= 1'b1;
            cnt       <= '0;
          end
        end
        st_wait: begin
          if (div_done) begin
            res_q <= div_R[W-1:0];
            res_r <= div_R[2*W-1:W];
          end else if (wd_fire) begin
            res_q  <= '0;
            res_r  <= '0;
            res_to <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        st_resp: begin
          resp_valid <= ONE << id;
          resp_q     <= res_q;
          resp_r     <= res_r;
          resp_dz    <= res_dz;
          resp_to    <= res_to;
          ptr        <= (id == IW'(N_REQ - 1)) ? '0 : id + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
